// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: reorder-buffer entry kinds and default geometry.
package rv32i_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int REG_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'b00,
        ROB_TYPE_STORE  = 2'b01,
        ROB_TYPE_BRANCH = 2'b10
    } rob_type_e;

    // Resolved branch direction lives in bit 0 of the entry value.
    function automatic logic rob_mispredict(input logic resolved_taken, input logic pred_taken);
        return resolved_taken ^ pred_taken;
    endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand-readiness lookup into the reorder buffer for one issue source operand.
// ROB_BYPASS_EN: also forward a same-cycle result broadcast to the queried entry.
module rob_query_port
    import rv32i_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int DEPTH     = 16
) (
    input  logic [ROB_WIDTH-1:0]        queryIndex,
    input  logic [DEPTH-1:0]            entryValid,
    input  logic [DEPTH-1:0]            entryReady,
    input  logic [DEPTH-1:0][31:0]      entryVal,
    input  logic                        rsUpdate,
    input  logic [ROB_WIDTH-1:0]        rsRobIndex,
    input  logic [31:0]                 rsUpdateVal,
    input  logic                        lsbUpdate,
    input  logic [ROB_WIDTH-1:0]        lsbRobIndex,
    input  logic [31:0]                 lsbUpdateVal,
    output logic                        queryReady,
    output logic [31:0]                 queryVal
);

`ifdef ROB_BYPASS_EN
    // Lookup with forwarding; only a pending entry can take a broadcast, LSB first.
    always_comb begin
        queryReady = 1'b1;
        queryVal   = 32'h0000_0000;
        if (!entryValid[queryIndex]) begin
            queryReady = 1'b1;
            queryVal   = 32'h0000_0000;
        end else if (!entryReady[queryIndex] && lsbUpdate && (lsbRobIndex == queryIndex)) begin
            queryReady = 1'b1;
            queryVal   = lsbUpdateVal;
        end else if (!entryReady[queryIndex] && rsUpdate && (rsRobIndex == queryIndex)) begin
            queryReady = 1'b1;
            queryVal   = rsUpdateVal;
        end else begin
            queryReady = entryReady[queryIndex];
            queryVal   = entryVal[queryIndex];
        end
    end
`else
    logic unused_bus_s;
    assign unused_bus_s = ^{rsUpdate, rsRobIndex, rsUpdateVal, lsbUpdate, lsbRobIndex, lsbUpdateVal};

    // Stored-state lookup; a producer with no live entry has already retired.
    always_comb begin
        queryReady = 1'b1;
        queryVal   = 32'h0000_0000;
        if (!entryValid[queryIndex]) begin
            queryReady = 1'b1;
            queryVal   = 32'h0000_0000;
        end else begin
            queryReady = entryReady[queryIndex];
            queryVal   = entryVal[queryIndex];
        end
    end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, capture broadcast results, retire at head.
// Define ROB_BYPASS_EN to let operand queries see same-cycle result broadcasts.
module reorder_buffer
    import rv32i_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int REG_WIDTH = REG_WIDTH_DEF
) (
    input  logic                    clockIn,
    input  logic                    resetIn,
    input  logic                    readyIn,
    input  logic                    issueValid,
    input  logic [1:0]              issueType,
    input  logic [REG_WIDTH-1:0]    issueDest,
    input  logic                    issueReady,
    input  logic [31:0]             issueVal,
    input  logic                    issuePredTaken,
    input  logic [31:0]             issueAltPc,
    output logic [ROB_WIDTH-1:0]    issueRobIndex,
    output logic                    full,
    input  logic                    rsUpdate,
    input  logic [ROB_WIDTH-1:0]    rsRobIndex,
    input  logic [31:0]             rsUpdateVal,
    input  logic                    lsbUpdate,
    input  logic [ROB_WIDTH-1:0]    lsbRobIndex,
    input  logic [31:0]             lsbUpdateVal,
    input  logic [ROB_WIDTH-1:0]    query1Index,
    input  logic [ROB_WIDTH-1:0]    query2Index,
    output logic                    query1Ready,
    output logic                    query2Ready,
    output logic [31:0]             query1Val,
    output logic [31:0]             query2Val,
    output logic                    commitRegValid,
    output logic [REG_WIDTH-1:0]    commitRegDest,
    output logic [31:0]             commitRegVal,
    output logic [ROB_WIDTH-1:0]    commitRobIndex,
    output logic                    storeCommitValid,
    output logic                    flushOut,
    output logic [31:0]             flushPc
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0]   CNT_FULL = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [ROB_WIDTH:0]   CNT_ONE  = {{ROB_WIDTH{1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH-1:0] PTR_ONE  = {{(ROB_WIDTH-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0]                valid_r;
    logic [DEPTH-1:0]                ready_r;
    logic [DEPTH-1:0][1:0]           type_r;
    logic [DEPTH-1:0][REG_WIDTH-1:0] dest_r;
    logic [DEPTH-1:0][31:0]          value_r;
    logic [DEPTH-1:0]                pred_r;
    logic [DEPTH-1:0][31:0]          alt_pc_r;
    logic [ROB_WIDTH-1:0]            head_r;
    logic [ROB_WIDTH-1:0]            tail_r;
    logic [ROB_WIDTH:0]              count_r;

    logic                            issue_acc_s;
    logic                            commit_s;
    logic                            mispredict_s;
    logic                            rs_upd_s;
    logic                            lsb_upd_s;
    rob_type_e                       head_type_s;
    logic [DEPTH-1:0]                rs_hit_s;
    logic [DEPTH-1:0]                lsb_hit_s;

    assign full          = (count_r == CNT_FULL);
    assign issueRobIndex = tail_r;
    assign rs_upd_s      = readyIn & rsUpdate;
    assign lsb_upd_s     = readyIn & lsbUpdate;
    assign issue_acc_s   = readyIn & issueValid & ~full;
    assign commit_s      = readyIn & valid_r[head_r] & ready_r[head_r];
    assign head_type_s   = rob_type_e'(type_r[head_r]);
    assign mispredict_s  = commit_s && (head_type_s == ROB_TYPE_BRANCH)
                           && rob_mispredict(value_r[head_r][0], pred_r[head_r]);

    // Broadcast hits only land on entries that are live and still waiting.
    always_comb begin
        rs_hit_s  = '0;
        lsb_hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit_s[i]  = rs_upd_s  && (rsRobIndex  == ROB_WIDTH'(i)) && valid_r[i] && !ready_r[i];
            lsb_hit_s[i] = lsb_upd_s && (lsbRobIndex == ROB_WIDTH'(i)) && valid_r[i] && !ready_r[i];
        end
    end

    // Entry storage: a mispredict wipes every entry and drops that cycle's issue and updates.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            valid_r  <= '0;
            ready_r  <= '0;
            type_r   <= '0;
            dest_r   <= '0;
            value_r  <= '0;
            pred_r   <= '0;
            alt_pc_r <= '0;
        end else if (mispredict_s) begin
            valid_r <= '0;
            ready_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lsb_hit_s[i]) begin
                    value_r[i] <= lsbUpdateVal;
                    ready_r[i] <= 1'b1;
                end else if (rs_hit_s[i]) begin
                    value_r[i] <= rsUpdateVal;
                    ready_r[i] <= 1'b1;
                end
            end
            if (commit_s) begin
                valid_r[head_r] <= 1'b0;
            end
            if (issue_acc_s) begin
                valid_r[tail_r]  <= 1'b1;
                ready_r[tail_r]  <= issueReady;
                type_r[tail_r]   <= issueType;
                dest_r[tail_r]   <= issueDest;
                value_r[tail_r]  <= issueVal;
                pred_r[tail_r]   <= issuePredTaken;
                alt_pc_r[tail_r] <= issueAltPc;
            end
        end
    end

    // Head/tail pointers and occupancy.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (mispredict_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (commit_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (issue_acc_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            case ({issue_acc_s, commit_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered retirement outputs; pulses last one cycle, payload holds until the next retire.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            commitRegValid   <= 1'b0;
            commitRegDest    <= '0;
            commitRegVal     <= 32'h0000_0000;
            commitRobIndex   <= '0;
            storeCommitValid <= 1'b0;
            flushOut         <= 1'b0;
            flushPc          <= 32'h0000_0000;
        end else begin
            commitRegValid   <= 1'b0;
            storeCommitValid <= 1'b0;
            flushOut         <= 1'b0;
            if (commit_s) begin
                commitRobIndex <= head_r;
                case (head_type_s)
                    ROB_TYPE_REG: begin
                        commitRegValid <= 1'b1;
                        commitRegDest  <= dest_r[head_r];
                        commitRegVal   <= value_r[head_r];
                    end
                    ROB_TYPE_STORE: begin
                        storeCommitValid <= 1'b1;
                    end
                    ROB_TYPE_BRANCH: begin
                        if (mispredict_s) begin
                            flushOut <= 1'b1;
                            flushPc  <= alt_pc_r[head_r];
                        end
                    end
                    default: begin
                        commitRegValid <= 1'b0;
                    end
                endcase
            end
        end
    end

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH), .DEPTH(DEPTH)) u_query1 (
        .queryIndex   (query1Index),
        .entryValid   (valid_r),
        .entryReady   (ready_r),
        .entryVal     (value_r),
        .rsUpdate     (rs_upd_s),
        .rsRobIndex   (rsRobIndex),
        .rsUpdateVal  (rsUpdateVal),
        .lsbUpdate    (lsb_upd_s),
        .lsbRobIndex  (lsbRobIndex),
        .lsbUpdateVal (lsbUpdateVal),
        .queryReady   (query1Ready),
        .queryVal     (query1Val)
    );

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH), .DEPTH(DEPTH)) u_query2 (
        .queryIndex   (query2Index),
        .entryValid   (valid_r),
        .entryReady   (ready_r),
        .entryVal     (value_r),
        .rsUpdate     (rs_upd_s),
        .rsRobIndex   (rsRobIndex),
        .rsUpdateVal  (rsUpdateVal),
        .lsbUpdate    (lsb_upd_s),
        .lsbRobIndex  (lsbRobIndex),
        .lsbUpdateVal (lsbUpdateVal),
        .queryReady   (query2Ready),
        .queryVal     (query2Val)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// compared against a queue-based in-order retirement model.
module tb_reorder_buffer;

    logic        clockIn, resetIn, readyIn;
    logic        issueValid, issueReady, issuePredTaken;
    logic [1:0]  issueType;
    logic [4:0]  issueDest;
    logic [31:0] issueVal, issueAltPc;
    logic [3:0]  issueRobIndex;
    logic        full;
    logic        rsUpdate, lsbUpdate;
    logic [3:0]  rsRobIndex, lsbRobIndex;
    logic [31:0] rsUpdateVal, lsbUpdateVal;
    logic [3:0]  query1Index, query2Index;
    logic        query1Ready, query2Ready;
    logic [31:0] query1Val, query2Val;
    logic        commitRegValid, storeCommitValid, flushOut;
    logic [4:0]  commitRegDest;
    logic [31:0] commitRegVal, flushPc;
    logic [3:0]  commitRobIndex;

    int total = 0;
    int bad   = 0;

    reorder_buffer dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
        .issueValid(issueValid), .issueType(issueType), .issueDest(issueDest),
        .issueReady(issueReady), .issueVal(issueVal), .issuePredTaken(issuePredTaken),
        .issueAltPc(issueAltPc), .issueRobIndex(issueRobIndex), .full(full),
        .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsUpdateVal(rsUpdateVal),
        .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal),
        .query1Index(query1Index), .query2Index(query2Index),
        .query1Ready(query1Ready), .query2Ready(query2Ready),
        .query1Val(query1Val), .query2Val(query2Val),
        .commitRegValid(commitRegValid), .commitRegDest(commitRegDest),
        .commitRegVal(commitRegVal), .commitRobIndex(commitRobIndex),
        .storeCommitValid(storeCommitValid), .flushOut(flushOut), .flushPc(flushPc)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    // ---------------- reference model: in-flight instructions in program order ----------------
    typedef struct {
        int         idx;
        bit         rdy;
        bit [1:0]   kind;
        bit [4:0]   dest;
        bit [31:0]  val;
        bit         pred;
        bit [31:0]  alt;
    } ent_t;

    ent_t       q[$];
    int         next_idx;
    bit         e_reg_v, e_store_v, e_flush;
    bit [4:0]   e_reg_dest;
    bit [31:0]  e_reg_val, e_flush_pc;
    logic [3:0] e_idx;

    function automatic void model_reset();
        q.delete();
        next_idx   = 0;
        e_reg_v    = 1'b0; e_store_v = 1'b0; e_flush = 1'b0;
        e_reg_dest = 5'd0; e_reg_val = 32'd0; e_flush_pc = 32'd0; e_idx = 4'd0;
    endfunction

    function automatic void model_query(input int qi, output bit r, output bit [31:0] v);
        r = 1'b1;
        v = 32'd0;
        foreach (q[i]) begin
            if (q[i].idx == qi) begin
                r = q[i].rdy;
                v = q[i].val;
`ifdef ROB_BYPASS_EN
                if (!q[i].rdy && readyIn) begin
                    if (lsbUpdate && int'(lsbRobIndex) == qi) begin
                        r = 1'b1; v = lsbUpdateVal;
                    end else if (rsUpdate && int'(rsRobIndex) == qi) begin
                        r = 1'b1; v = rsUpdateVal;
                    end
                end
`endif
            end
        end
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit   was_full;
        bit   flush;
        ent_t e;
        e_reg_v = 1'b0; e_store_v = 1'b0; e_flush = 1'b0;
        if (!readyIn) return;
        was_full = (q.size() == 16);
        flush    = 1'b0;
        if (q.size() > 0 && q[0].rdy) begin
            e = q.pop_front();
            e_idx = 4'(e.idx);
            case (e.kind)
                2'd0: begin e_reg_v = 1'b1; e_reg_dest = e.dest; e_reg_val = e.val; end
                2'd1: e_store_v = 1'b1;
                2'd2: if (e.val[0] != e.pred) begin e_flush = 1'b1; e_flush_pc = e.alt; flush = 1'b1; end
                default: ;
            endcase
        end
        if (flush) begin
            q.delete();
            next_idx = 0;
            return;
        end
        foreach (q[i]) begin
            if (!q[i].rdy) begin
                if (lsbUpdate && int'(lsbRobIndex) == q[i].idx) begin
                    q[i].val = lsbUpdateVal; q[i].rdy = 1'b1;
                end else if (rsUpdate && int'(rsRobIndex) == q[i].idx) begin
                    q[i].val = rsUpdateVal; q[i].rdy = 1'b1;
                end
            end
        end
        if (issueValid && !was_full) begin
            e.idx = next_idx; e.rdy = issueReady; e.kind = issueType; e.dest = issueDest;
            e.val = issueVal; e.pred = issuePredTaken; e.alt = issueAltPc;
            q.push_back(e);
            next_idx = (next_idx + 1) % 16;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clockIn);
        #1;
    endtask

    task automatic clear_inputs();
        readyIn = 1'b1; issueValid = 1'b0; issueType = 2'd0; issueDest = 5'd0;
        issueReady = 1'b0; issueVal = 32'd0; issuePredTaken = 1'b0; issueAltPc = 32'd0;
        rsUpdate = 1'b0; rsRobIndex = 4'd0; rsUpdateVal = 32'd0;
        lsbUpdate = 1'b0; lsbRobIndex = 4'd0; lsbUpdateVal = 32'd0;
        query1Index = 4'd0; query2Index = 4'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetIn = 1'b0;
        model_reset();
        @(posedge clockIn);
        #3;
        resetIn = 1'b1;
    endtask

    task automatic issue(input bit [1:0] t, input bit [4:0] d, input bit r, input bit [31:0] v,
                         input bit p, input bit [31:0] a);
        issueValid = 1'b1; issueType = t; issueDest = d; issueReady = r;
        issueVal = v; issuePredTaken = p; issueAltPc = a;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        issue(2'd0, 5'd7, 1'b1, 32'h55, 1'b0, 32'd0);
        tick();
        tick();
        issueValid = 1'b0;
        query1Index = 4'd1;
        #2;
        resetIn = 1'b0;
        model_reset();
        #1;
        total++; if (commitRegValid !== 1'b0) begin bad++; $display("FAIL reset_regvalid: got %0b expected 0", commitRegValid); end
        total++; if (commitRegDest !== 5'd0) begin bad++; $display("FAIL reset_regdest: got %0h expected 0", commitRegDest); end
        total++; if (commitRegVal !== 32'd0) begin bad++; $display("FAIL reset_regval: got %0h expected 0", commitRegVal); end
        total++; if (storeCommitValid !== 1'b0 || flushOut !== 1'b0) begin bad++; $display("FAIL reset_pulses: got store=%0b flush=%0b expected 0", storeCommitValid, flushOut); end
        total++; if (flushPc !== 32'd0 || commitRobIndex !== 4'd0) begin bad++; $display("FAIL reset_pc_idx: got pc=%0h idx=%0h expected 0", flushPc, commitRobIndex); end
        total++; if (issueRobIndex !== 4'd0 || full !== 1'b0) begin bad++; $display("FAIL reset_tail_full: got idx=%0h full=%0b expected 0", issueRobIndex, full); end
        total++; if (query1Ready !== 1'b1 || query1Val !== 32'd0) begin bad++; $display("FAIL reset_query: got rdy=%0b val=%0h expected 1/0", query1Ready, query1Val); end
        #2;
        resetIn = 1'b1;
    endtask

    task automatic test_issue_commit();
        do_reset();
        issue(2'd0, 5'd5, 1'b1, 32'h1234, 1'b0, 32'd0);
        tick();
        issueValid = 1'b0;
        total++; if (commitRegValid !== 1'b0) begin bad++; $display("FAIL early_commit: got %0b expected 0", commitRegValid); end
        tick();
        total++; if (commitRegValid !== 1'b1 || commitRegDest !== 5'd5 || commitRegVal !== 32'h1234 || commitRobIndex !== 4'd0)
            begin bad++; $display("FAIL reg_commit: got v=%0b d=%0d val=%0h idx=%0d expected 1/5/1234/0", commitRegValid, commitRegDest, commitRegVal, commitRobIndex); end
        tick();
        total++; if (commitRegValid !== 1'b0) begin bad++; $display("FAIL pulse_width: got %0b expected 0", commitRegValid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(2'd0, 5'(i), 1'b0, 32'(i), 1'b0, 32'd0);
            tick();
        end
        issueValid = 1'b0;
        #1;
        total++; if (full !== 1'b1 || issueRobIndex !== 4'd0) begin bad++; $display("FAIL full_set: got full=%0b idx=%0d expected 1/0", full, issueRobIndex); end
        issueValid = 1'b1;
        tick();
        total++; if (issueRobIndex !== 4'd0 || full !== 1'b1) begin bad++; $display("FAIL full_refuse: got idx=%0d full=%0b expected 0/1", issueRobIndex, full); end
        issueValid = 1'b0;
        rsUpdate = 1'b1; rsRobIndex = 4'd0; rsUpdateVal = 32'hBEEF;
        tick();
        rsUpdate = 1'b0;
        total++; if (commitRegValid !== 1'b0 || full !== 1'b1) begin bad++; $display("FAIL full_pre_commit: got v=%0b full=%0b expected 0/1", commitRegValid, full); end
        issueValid = 1'b1;
        tick();
        issueValid = 1'b0;
        total++; if (commitRegValid !== 1'b1 || commitRobIndex !== 4'd0 || commitRegVal !== 32'hBEEF)
            begin bad++; $display("FAIL full_commit: got v=%0b idx=%0d val=%0h expected 1/0/beef", commitRegValid, commitRobIndex, commitRegVal); end
        total++; if (full !== 1'b0 || issueRobIndex !== 4'd0) begin bad++; $display("FAIL full_clear: got full=%0b idx=%0d expected 0/0", full, issueRobIndex); end
    endtask

    task automatic test_in_order();
        do_reset();
        issue(2'd0, 5'd10, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        issue(2'd0, 5'd11, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        issueValid = 1'b0;
        rsUpdate = 1'b1; rsRobIndex = 4'd1; rsUpdateVal = 32'hB;
        tick();
        total++; if (commitRegValid !== 1'b0) begin bad++; $display("FAIL order_hold: got %0b expected 0", commitRegValid); end
        rsRobIndex = 4'd0; rsUpdateVal = 32'hA;
        tick();
        rsUpdate = 1'b0;
        total++; if (commitRegValid !== 1'b0) begin bad++; $display("FAIL order_latency: got %0b expected 0", commitRegValid); end
        tick();
        total++; if (commitRegValid !== 1'b1 || commitRobIndex !== 4'd0 || commitRegVal !== 32'hA)
            begin bad++; $display("FAIL order_first: got v=%0b idx=%0d val=%0h expected 1/0/a", commitRegValid, commitRobIndex, commitRegVal); end
        tick();
        total++; if (commitRegValid !== 1'b1 || commitRobIndex !== 4'd1 || commitRegDest !== 5'd11)
            begin bad++; $display("FAIL order_second: got v=%0b idx=%0d d=%0d expected 1/1/11", commitRegValid, commitRobIndex, commitRegDest); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h100);
        tick();
        issue(2'd0, 5'd1, 1'b1, 32'd11, 1'b0, 32'd0);
        tick();
        issue(2'd0, 5'd2, 1'b1, 32'd22, 1'b0, 32'd0);
        tick();
        issueValid = 1'b0;
        rsUpdate = 1'b1; rsRobIndex = 4'd0; rsUpdateVal = 32'd0;
        tick();
        rsUpdate = 1'b0;
        total++; if (flushOut !== 1'b0) begin bad++; $display("FAIL flush_early: got %0b expected 0", flushOut); end
        issue(2'd0, 5'd9, 1'b1, 32'd99, 1'b0, 32'd0);
        tick();
        issueValid = 1'b0;
        total++; if (flushOut !== 1'b1 || flushPc !== 32'h100 || commitRobIndex !== 4'd0)
            begin bad++; $display("FAIL flush_pulse: got f=%0b pc=%0h idx=%0d expected 1/100/0", flushOut, flushPc, commitRobIndex); end
        total++; if (issueRobIndex !== 4'd0 || full !== 1'b0) begin bad++; $display("FAIL flush_tail: got idx=%0d full=%0b expected 0/0", issueRobIndex, full); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (commitRegValid !== 1'b0 || flushOut !== 1'b0 || storeCommitValid !== 1'b0)
                begin bad++; $display("FAIL flush_squash: got reg=%0b flush=%0b st=%0b expected 0", commitRegValid, flushOut, storeCommitValid); end
        end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(2'd0, 5'(i), 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
        end
        issueValid = 1'b0;
        query1Index = 4'd3; query2Index = 4'd9;
        rsUpdate = 1'b1; rsRobIndex = 4'd3; rsUpdateVal = 32'd7;
        #1;
        total++; if (query2Ready !== 1'b1 || query2Val !== 32'd0) begin bad++; $display("FAIL query_invalid: got rdy=%0b val=%0h expected 1/0", query2Ready, query2Val); end
`ifdef ROB_BYPASS_EN
        total++; if (query1Ready !== 1'b1 || query1Val !== 32'd7) begin bad++; $display("FAIL query_bypass: got rdy=%0b val=%0h expected 1/7", query1Ready, query1Val); end
`else
        total++; if (query1Ready !== 1'b0) begin bad++; $display("FAIL query_nobypass: got rdy=%0b expected 0", query1Ready); end
`endif
        tick();
        rsUpdate = 1'b0;
        #1;
        total++; if (query1Ready !== 1'b1 || query1Val !== 32'd7) begin bad++; $display("FAIL query_stored: got rdy=%0b val=%0h expected 1/7", query1Ready, query1Val); end
        rsUpdate = 1'b1; rsRobIndex = 4'd2; rsUpdateVal = 32'h11;
        lsbUpdate = 1'b1; lsbRobIndex = 4'd2; lsbUpdateVal = 32'h22;
        tick();
        rsUpdate = 1'b0; lsbUpdate = 1'b0;
        query1Index = 4'd2;
        #1;
        total++; if (query1Ready !== 1'b1 || query1Val !== 32'h22) begin bad++; $display("FAIL lsb_priority: got rdy=%0b val=%0h expected 1/22", query1Ready, query1Val); end
    endtask

    task automatic test_stall();
        do_reset();
        issue(2'd0, 5'd3, 1'b1, 32'hAB, 1'b0, 32'd0);
        tick();
        issue(2'd0, 5'd4, 1'b1, 32'hCD, 1'b0, 32'd0);
        tick();
        total++; if (commitRegValid !== 1'b1 || commitRobIndex !== 4'd0) begin bad++; $display("FAIL stall_first: got v=%0b idx=%0d expected 1/0", commitRegValid, commitRobIndex); end
        readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (commitRegValid !== 1'b0 || issueRobIndex !== 4'd2)
                begin bad++; $display("FAIL stall_hold: got v=%0b idx=%0d expected 0/2", commitRegValid, issueRobIndex); end
        end
        readyIn = 1'b1;
        issueValid = 1'b0;
        tick();
        total++; if (commitRegValid !== 1'b1 || commitRobIndex !== 4'd1 || commitRegVal !== 32'hCD)
            begin bad++; $display("FAIL stall_resume: got v=%0b idx=%0d val=%0h expected 1/1/cd", commitRegValid, commitRobIndex, commitRegVal); end
    endtask

    function automatic logic [3:0] pick_idx();
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
            return 4'(q[$urandom_range(0, q.size() - 1)].idx);
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        bit        r1, r2;
        bit [31:0] v1, v2;
        int        br;
        int        upd;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            br  = (c < 300) ? 0 : 2;
            upd = (c < 300) ? 5 : 1;
            readyIn        = ($urandom_range(0, 9) != 0);
            issueValid     = ($urandom_range(0, 3) != 0);
            issueType      = ($urandom_range(0, 9) < br) ? 2'd2 : 2'($urandom_range(0, 1));
            issueDest      = 5'($urandom);
            issueReady     = ($urandom_range(0, 3) == 0);
            issueVal       = $urandom;
            issuePredTaken = 1'($urandom_range(0, 1));
            issueAltPc     = $urandom;
            rsUpdate       = ($urandom_range(0, upd) == 0);
            rsRobIndex     = pick_idx();
            rsUpdateVal    = $urandom;
            lsbUpdate      = ($urandom_range(0, upd) == 0);
            lsbRobIndex    = pick_idx();
            lsbUpdateVal   = $urandom;
            query1Index    = pick_idx();
            query2Index    = 4'($urandom_range(0, 15));
            #1;
            model_query(int'(query1Index), r1, v1);
            model_query(int'(query2Index), r2, v2);
            total++; if (query1Ready !== r1 || query1Val !== v1) begin bad++; $display("FAIL rnd_query1 c=%0d: got %0b/%0h expected %0b/%0h", c, query1Ready, query1Val, r1, v1); end
            total++; if (query2Ready !== r2 || query2Val !== v2) begin bad++; $display("FAIL rnd_query2 c=%0d: got %0b/%0h expected %0b/%0h", c, query2Ready, query2Val, r2, v2); end
            total++; if (full !== (q.size() == 16) || int'(issueRobIndex) != next_idx)
                begin bad++; $display("FAIL rnd_occupancy c=%0d: got full=%0b idx=%0d expected %0b/%0d", c, full, issueRobIndex, q.size() == 16, next_idx); end
            tick();
            total++; if (commitRegValid !== e_reg_v || storeCommitValid !== e_store_v || flushOut !== e_flush)
                begin bad++; $display("FAIL rnd_pulses c=%0d: got %0b%0b%0b expected %0b%0b%0b", c, commitRegValid, storeCommitValid, flushOut, e_reg_v, e_store_v, e_flush); end
            total++; if (commitRobIndex !== e_idx || commitRegDest !== e_reg_dest || commitRegVal !== e_reg_val || flushPc !== e_flush_pc)
                begin bad++; $display("FAIL rnd_payload c=%0d: got %0d/%0d/%0h/%0h expected %0d/%0d/%0h/%0h", c, commitRobIndex, commitRegDest, commitRegVal, flushPc, e_idx, e_reg_dest, e_reg_val, e_flush_pc); end
        end
    endtask

    initial begin
        resetIn = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        resetIn = 1'b1;
        test_reset();
        test_issue_commit();
        test_full();
        test_in_order();
        test_flush();
        test_query();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
